// File: rtl/controle_medicao_periodica.sv
// Periodic measurement sequencer for the HC-SR04 interface: fires medir every
// INTERVALO cycles, waits for pronto with a timeout and averages four samples.
module controle_medicao_periodica #(
  parameter int W         = 12,
  parameter int INTERVALO = 3000000,
  parameter int TIMEOUT   = 1500000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         parar,
  input  logic         pronto,
  input  logic [W-1:0] medida,
  output logic         medir,
  output logic [W-1:0] media,
  output logic         media_valida,
  output logic         erro_timeout,
  output logic [3:0]   db_estado
);

  localparam int CW = $clog2(INTERVALO);
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(TIMEOUT);
  // cnt is 0 in the cycle after DISPARA, so leaving ESPERA at INTERVALO-2
  // puts the next DISPARA exactly INTERVALO cycles after the previous one.
  localparam logic [CW-1:0] CNT_FIM     = CW'(INTERVALO - 2);

  typedef enum logic [3:0] {
    OCIOSO  = 4'b0000,
    DISPARA = 4'b0001,
    AGUARDA = 4'b0010,
    ACUMULA = 4'b0011,
    CALCULA = 4'b0100,
    ESPERA  = 4'b0101
  } estado_t;

  estado_t        estado;
  logic [CW-1:0]  cnt;
  logic [W+1:0]   soma;
  logic [W+1:0]   soma_total;
  logic [1:0]     n;
  logic [W-1:0]   amostra;

  assign soma_total = soma + {2'b00, amostra};
  assign db_estado  = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      soma         <= '0;
      n            <= '0;
      amostra      <= '0;
      media        <= '0;
      erro_timeout <= 1'b0;
      medir        <= 1'b0;
      media_valida <= 1'b0;
    end else begin
      // Moore strobes are registered alongside the state they belong to
      medir        <= 1'b0;
      media_valida <= 1'b0;
      if (parar && estado != OCIOSO) begin
        estado <= OCIOSO;
        cnt    <= '0;
        soma   <= '0;
        n      <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (iniciar) begin
              estado <= DISPARA;
              medir  <= 1'b1;
            end
          end
          DISPARA: begin
            cnt    <= '0;
            estado <= AGUARDA;
          end
          AGUARDA: begin
            cnt <= cnt + 1'b1;
            if (pronto) begin
              amostra      <= medida;
              erro_timeout <= 1'b0;
              estado       <= ACUMULA;
            end else if (cnt == CNT_TIMEOUT) begin
              erro_timeout <= 1'b1;
              estado       <= ESPERA;
            end
          end
          ACUMULA: begin
            cnt <= cnt + 1'b1;
            if (n == 2'd3) begin
              media        <= soma_total[W+1:2];
              soma         <= '0;
              n            <= '0;
              estado       <= CALCULA;
              media_valida <= 1'b1;
            end else begin
              soma   <= soma_total;
              n      <= n + 1'b1;
              estado <= ESPERA;
            end
          end
          CALCULA: begin
            cnt    <= cnt + 1'b1;
            estado <= ESPERA;
          end
          ESPERA: begin
            cnt <= cnt + 1'b1;
            if (cnt >= CNT_FIM) begin
              estado <= DISPARA;
              medir  <= 1'b1;
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule
